pipelined_mac: RTL and testbench
================================

# pipelined_mac

Parametrised, pipelined multiply-accumulate unit and the sequential successor to the combinational 16×16 multiplier integration test. It computes a signed or unsigned product of two operands over a configurable number of register stages, optionally accumulating into a wide output register. It supports a global clock enable for stalls. It is written so that Lakeroad's DSP template can map it onto a single DSP48E2 (A/B, M and P registers), and it is exercised by a new integration test with `--pipeline-depth` equal to `PIPELINE_DEPTH`.

## Interface
Parameters:
- `WIDTH`, default 16: operand width of `a` and `b`; legal range 2..18.
- `OUT_WIDTH`, default 32: width of the product/accumulator; legal range 2·WIDTH..48.
- `PIPELINE_DEPTH`, default 3: cycles from input sample to `out_valid`; legal range 1..4.
- `SIGNED`, default 0: 1 treats `a` and `b` as two's complement and sign-extends the product; 0 treats them as unsigned.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ce`  in  1  clock enable; when 0, every register holds.
- `in_valid`  in  1  `a`, `b` and `acc_en` are sampled this cycle.
- `a`  in  WIDTH  multiplicand.
- `b`  in  WIDTH  multiplier.
- `acc_en`  in  1  1: add the product to the current `p`; 0: load the product into `p`.
- `out_valid`  out  1  `p` was updated by a valid operation this cycle.
- `p`  out  OUT_WIDTH  accumulator / result register.

## Operation
- Datapath is a shift chain of `PIPELINE_DEPTH` register stages. The last stage is always the `p` register.
  - Stage 1, when `PIPELINE_DEPTH` ≥ 2: registers `a`, `b`, `in_valid` and `acc_en`.
  - Stage 2, when `PIPELINE_DEPTH` ≥ 3: registers the full 2·WIDTH product.
  - Stage 3, when `PIPELINE_DEPTH` = 4: extra product register.
  - Stages are removed from the front as depth shrinks. At depth 1 the product of the current inputs feeds the `p` update directly.
- Every stage carries `valid` and `acc_en` alongside its data.
- Product extension to OUT_WIDTH:
  - `SIGNED`=1: sign-extend the 2·WIDTH product.
  - `SIGNED`=0: zero-extend.
- Final-stage update, when `ce`=1 and final valid=1:
  - acc_en=0: `p` ← ext(product).
  - acc_en=1: `p` ← `p` + ext(product), modulo 2^OUT_WIDTH. No saturation; wrap is silent.
- Final stage with valid=0 and `ce`=1: `p` holds and `out_valid` ← 0.
- Bubbles (`in_valid`=0) flow through the pipeline and never alter `p`.
- Back-to-back valid inputs are allowed. Accumulation uses the `p` value just produced by the preceding operation, so consecutive operations chain correctly with no hazard.
- Operands in flight do not interact except through `p`. Each pipeline stage holds an independent operation.

## Timing
- Reset (`rst_n`=0, asynchronous assert): all stage valids, `out_valid` and `p` go to 0 immediately, and all stage data registers go to 0.
  - Deassertion is sampled synchronously at the next `clk` edge.
  - Operations in flight at reset are discarded. The first operation after reset with acc_en=1 accumulates onto 0.
- Latency: `in_valid` high on cycle N with `ce` high every cycle yields `out_valid`=1 and the updated `p` after edge N+`PIPELINE_DEPTH`-1 (visible in cycle N+`PIPELINE_DEPTH`).
- Throughput: one operation per cycle.
- `ce`=0 freezes every stage, including `p` and `out_valid`. Inputs are not sampled. Latency extends by the number of stalled cycles.
- `out_valid` is a registered pulse per operation. It stays high across consecutive valid results.
- `ce`=0 together with `in_valid`=1: the input is dropped.
- Simultaneous reset and `ce`: reset wins.

## Test plan
- Reset then depth-3 unsigned load: `a`=300, `b`=200, acc_en=0 -> `out_valid` high exactly 3 cycles later with `p`=60000; `p` holds afterwards.
- Accumulate chain, back-to-back: (3,4,acc_en=0), (5,6,1), (7,8,1) on consecutive cycles -> `p` sequence 12, 42, 98 on three consecutive `out_valid` cycles.
- Signed mode (`SIGNED`=1, WIDTH=16, OUT_WIDTH=32): `a`=16'hFFFF, `b`=16'h0002 -> `p`=32'hFFFFFFFE. Then accumulate (-1)·(-1) -> `p`=32'hFFFFFFFF.
- Wrap-around (OUT_WIDTH=32): load 65535·65535 (=32'hFFFE0001), then accumulate 65535·65535 -> `p`=32'hFFFC0002, with no flag and no saturation.
- Stall and bubble: issue (2,3,0), drop `ce` for 2 cycles mid-pipeline, insert one `in_valid`=0 cycle, then issue (1,1,1) -> `out_valid` for the first result appears 2 cycles late with `p`=6; next result `p`=7; no `out_valid` during stall or for the bubble.
- Reset mid-operation: issue (9,9,0), assert `rst_n`=0 asynchronously one cycle later -> `p`=0 and `out_valid`=0 immediately; no result emerges after release. Then (2,2,1) -> `p`=4.
- Random compare against a behavioural MAC model for every `PIPELINE_DEPTH` in 1..4, with `SIGNED` at 0 and at 1.

Source files
------------

// File: rtl/pipelined_mac.sv
// Pipelined signed/unsigned multiply-accumulate into a wide p register.
// Latency PIPELINE_DEPTH cycles from in_valid to out_valid; one operation per cycle.
// No backpressure: ce=0 freezes every stage and drops the inputs of that cycle.
module pipelined_mac #(
    parameter int WIDTH          = 16,
    parameter int OUT_WIDTH      = 32,
    parameter int PIPELINE_DEPTH = 3,
    parameter int SIGNED         = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 acc_en,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] p
);
    localparam int PW = 2 * WIDTH;

    // Stage 1 view: operands plus their valid/acc_en tags
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_vld;
    logic             s1_acc;

    // Stage 2 view: first product register
    logic [PW-1:0]    prod;
    logic [PW-1:0]    s2_prod;
    logic             s2_vld;
    logic             s2_acc;

    // Stage 3 view: second product register, feeds the p update
    logic [PW-1:0]    s3_prod;
    logic             s3_vld;
    logic             s3_acc;

    logic [OUT_WIDTH-1:0] prod_ext;

    generate
        if (PIPELINE_DEPTH >= 2) begin : g_s1_reg
            // Operand register (DSP A/B stage)
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_a   <= '0;
                    s1_b   <= '0;
                    s1_vld <= 1'b0;
                    s1_acc <= 1'b0;
                end else if (ce) begin
                    s1_a   <= a;
                    s1_b   <= b;
                    s1_vld <= in_valid;
                    s1_acc <= acc_en;
                end
            end
        end else begin : g_s1_pass
            assign s1_a   = a;
            assign s1_b   = b;
            assign s1_vld = in_valid;
            assign s1_acc = acc_en;
        end

        // Full-width product; the signed form sign-extends operands before multiplying
        if (SIGNED != 0) begin : g_mul_s
            assign prod = PW'($signed(s1_a)) * PW'($signed(s1_b));
        end else begin : g_mul_u
            assign prod = PW'(s1_a) * PW'(s1_b);
        end

        if (PIPELINE_DEPTH >= 3) begin : g_s2_reg
            // Product register (DSP M stage)
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_prod <= '0;
                    s2_vld  <= 1'b0;
                    s2_acc  <= 1'b0;
                end else if (ce) begin
                    s2_prod <= prod;
                    s2_vld  <= s1_vld;
                    s2_acc  <= s1_acc;
                end
            end
        end else begin : g_s2_pass
            assign s2_prod = prod;
            assign s2_vld  = s1_vld;
            assign s2_acc  = s1_acc;
        end

        if (PIPELINE_DEPTH >= 4) begin : g_s3_reg
            // Extra product register for the deepest configuration
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s3_prod <= '0;
                    s3_vld  <= 1'b0;
                    s3_acc  <= 1'b0;
                end else if (ce) begin
                    s3_prod <= s2_prod;
                    s3_vld  <= s2_vld;
                    s3_acc  <= s2_acc;
                end
            end
        end else begin : g_s3_pass
            assign s3_prod = s2_prod;
            assign s3_vld  = s2_vld;
            assign s3_acc  = s2_acc;
        end

        // Extend the product to the accumulator width according to signedness
        if (SIGNED != 0) begin : g_ext_s
            assign prod_ext = OUT_WIDTH'($signed(s3_prod));
        end else begin : g_ext_u
            assign prod_ext = OUT_WIDTH'(s3_prod);
        end
    endgenerate

    // Final P stage: load or wrap-around accumulate; bubbles leave p untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p         <= '0;
            out_valid <= 1'b0;
        end else if (ce) begin
            out_valid <= s3_vld;
            if (s3_vld) begin
                p <= s3_acc ? (p + prod_ext) : prod_ext;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_mac.sv
// Drives eight pipelined_mac instances (depth 1..4, unsigned and signed) with
// one shared stimulus stream and checks each against a scoreboard of expected
// p values tagged with the ce-cycle on which each result must appear.
module tb_pipelined_mac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        in_valid;
    logic        acc_en;
    logic [15:0] a;
    logic [15:0] b;

    logic [7:0]  ov;
    logic [31:0] pv [8];

    always #5 clk = ~clk;

    // Instance i: PIPELINE_DEPTH = (i % 4) + 1, SIGNED = i / 4
    for (genvar gi = 0; gi < 8; gi++) begin : g_dut
        pipelined_mac #(
            .WIDTH          (16),
            .OUT_WIDTH      (32),
            .PIPELINE_DEPTH ((gi % 4) + 1),
            .SIGNED         (gi / 4)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .ce        (ce),
            .in_valid  (in_valid),
            .a         (a),
            .b         (b),
            .acc_en    (acc_en),
            .out_valid (ov[gi]),
            .p         (pv[gi])
        );
    end

    typedef struct {
        logic [31:0] pu;
        logic [31:0] ps;
        int          issue;
    } rec_t;

    rec_t        sb_q [$];
    int          rd [8];
    logic        exp_ov [8];
    logic [31:0] last_p [8];
    logic [31:0] mu;
    logic [31:0] ms;
    int          tick;
    int          checks;
    int          errors;

    localparam int U3 = 2;  // depth 3, unsigned
    localparam int S3 = 6;  // depth 3, signed

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Behavioural MAC: results chain in issue order, independent of depth
    task automatic push(input logic [15:0] ia, input logic [15:0] ib, input logic iacc);
        rec_t        r;
        logic [31:0] ep;
        int          sp;
        ep = {16'b0, ia} * {16'b0, ib};
        sp = int'($signed(ia)) * int'($signed(ib));
        mu = iacc ? (mu + ep) : ep;
        ms = iacc ? (ms + sp) : sp;
        r.pu    = mu;
        r.ps    = ms;
        r.issue = tick + 1;
        sb_q.push_back(r);
    endtask

    task automatic monitor(input logic edge_ce);
        logic hit;
        for (int i = 0; i < 8; i++) begin
            if (!rst_n) begin
                exp_ov[i] = 1'b0;
                last_p[i] = '0;
            end else if (edge_ce) begin
                hit = 1'b0;
                if (rd[i] < sb_q.size())
                    hit = (sb_q[rd[i]].issue + (i % 4) == tick);
                if (hit) begin
                    last_p[i] = (i >= 4) ? sb_q[rd[i]].ps : sb_q[rd[i]].pu;
                    rd[i]++;
                end
                exp_ov[i] = hit;
            end
            cmp($sformatf("out_valid d%0d s%0d t%0d", (i % 4) + 1, i / 4, tick),
                {31'b0, ov[i]}, {31'b0, exp_ov[i]});
            cmp($sformatf("p d%0d s%0d t%0d", (i % 4) + 1, i / 4, tick), pv[i], last_p[i]);
        end
    endtask

    // One clock: apply inputs, record the issue, then check at the falling edge
    task automatic drive(input logic c, input logic v, input logic [15:0] ia,
                         input logic [15:0] ib, input logic iacc);
        logic ec;
        ce       = c;
        in_valid = v;
        a        = ia;
        b        = ib;
        acc_en   = iacc;
        ec = c && rst_n;
        if (ec && v) push(ia, ib, iacc);
        @(posedge clk);
        if (ec) tick++;
        @(negedge clk);
        monitor(ec);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        checks = 0;
        errors = 0;
        tick   = 0;
        mu     = '0;
        ms     = '0;
        for (int i = 0; i < 8; i++) begin
            rd[i]     = 0;
            exp_ov[i] = 1'b0;
            last_p[i] = '0;
        end
        rst_n = 1'b1; ce = 1'b0; in_valid = 1'b0; acc_en = 1'b0; a = '0; b = '0;
        #2 rst_n = 1'b0;
        drive(1'b1, 1'b1, 16'd5, 16'd5, 1'b0);   // sampled under reset: ignored
        drive(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
        rst_n = 1'b1;
        idle(2);

        // Depth-3 unsigned load with exact latency, then hold
        drive(1'b1, 1'b1, 16'd300, 16'd200, 1'b0);
        idle(5);
        cmp("load 300*200", pv[U3], 32'd60000);

        // Back-to-back accumulate chain
        drive(1'b1, 1'b1, 16'd3, 16'd4, 1'b0);
        drive(1'b1, 1'b1, 16'd5, 16'd6, 1'b1);
        drive(1'b1, 1'b1, 16'd7, 16'd8, 1'b1);
        idle(5);
        for (int i = 0; i < 8; i++) cmp($sformatf("chain end dut%0d", i), pv[i], 32'd98);

        // Signed vs unsigned interpretation of the same bits
        drive(1'b1, 1'b1, 16'hFFFF, 16'h0002, 1'b0);
        idle(5);
        cmp("signed -1*2", pv[S3], 32'hFFFF_FFFE);
        cmp("unsigned 65535*2", pv[U3], 32'h0001_FFFE);
        drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        idle(5);
        cmp("signed acc -1*-1", pv[S3], 32'hFFFF_FFFF);
        cmp("unsigned acc max*max", pv[U3], 32'hFFFF_FFFF);

        // Silent wrap-around of the accumulator
        drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        idle(5);
        cmp("wrap unsigned", pv[U3], 32'hFFFC_0002);
        cmp("wrap signed", pv[S3], 32'h0000_0002);

        // Stall (with a dropped input), bubble, then accumulate
        drive(1'b1, 1'b1, 16'd2, 16'd3, 1'b0);
        drive(1'b0, 1'b1, 16'd7, 16'd7, 1'b1);
        drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        drive(1'b1, 1'b0, 16'd9, 16'd9, 1'b1);
        drive(1'b1, 1'b1, 16'd1, 16'd1, 1'b1);
        idle(5);
        for (int i = 0; i < 8; i++) cmp($sformatf("stall end dut%0d", i), pv[i], 32'd7);

        // Asynchronous reset with an operation in flight
        drive(1'b1, 1'b1, 16'd9, 16'd9, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            cmp($sformatf("async rst ov dut%0d", i), {31'b0, ov[i]}, 32'd0);
            cmp($sformatf("async rst p dut%0d", i), pv[i], 32'd0);
            rd[i] = sb_q.size();
        end
        mu = '0;
        ms = '0;
        drive(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
        drive(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
        rst_n = 1'b1;
        idle(5);
        drive(1'b1, 1'b1, 16'd2, 16'd2, 1'b1);
        idle(5);
        for (int i = 0; i < 8; i++) cmp($sformatf("post rst acc dut%0d", i), pv[i], 32'd4);

        // Random traffic with stalls, bubbles and extreme operands
        for (int n = 0; n < 300; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
            if ($urandom_range(0, 7) == 0) rb = 16'h8000;
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, ra, rb,
                  $urandom_range(0, 2) != 0);
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
